// File: rtl/riscv_fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, instruction buffer to decoder (option: RISCV_FETCH_MISALIGN_CHECK_EN).
// Latency: a response taken at edge N is presented the cycle after N; 2 cycles request-to-decoder minimum.
// Backpressure: instr_ready low fills the buffer; requests stop once outstanding+buffered reaches FIFO_DEPTH.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
  output logic        fetch_misaligned,
  output logic [31:0] misaligned_pc,
`endif
  output logic [31:0] instr_pc
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dat;
  } entry_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, rsp_pc, redir_addr;
  logic [CW-1:0] count, outstanding, out_d, drop_cnt;
  logic [CW:0]   inflight;
  logic [AW-1:0] wr_ptr, rd_ptr;
  entry_t        fifo_mem [FIFO_DEPTH];
  entry_t        head;
  logic          req_fire, push, pop, redir_misaligned;

  assign redir_addr     = redirect_pc & 32'hFFFF_FFFC;
  assign inflight       = {1'b0, outstanding} + {1'b0, count};
  assign imem_req_valid = ~rst & (state_q == FETCH) & ~redirect_valid
                        & (inflight < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // Stale responses (drop_cnt>0) and responses landing in a redirect cycle never enter the buffer.
  assign push        = imem_rsp_valid & (drop_cnt == '0) & ~redirect_valid;
  assign instr_valid = ~rst & (count != '0) & ~redirect_valid;
  assign pop         = instr_valid & instr_ready;
  assign head        = fifo_mem[rd_ptr];
  assign instruction = head.dat;
  assign instr_pc    = head.pc;

  always_comb begin
    out_d = outstanding;
    if (req_fire && !imem_rsp_valid)
      out_d = outstanding + 1'b1;
    else if (!req_fire && imem_rsp_valid)
      out_d = outstanding - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {rsp_pc, imem_rsp_data};
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_d;
      if (redirect_valid) begin
        pc_q     <= redir_addr;
        rsp_pc   <= redir_addr;
        drop_cnt <= out_d;
      end else begin
        if (req_fire) pc_q <= pc_q + 32'd4;
        if (push)     rsp_pc <= rsp_pc + 32'd4;
        if (imem_rsp_valid && drop_cnt != '0)
          drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE)
      state_d = FETCH;
    if (redirect_valid)
      state_d = redir_misaligned ? HALT : FETCH;
  end

`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
  assign redir_misaligned = |redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_misaligned <= 1'b0;
      misaligned_pc    <= '0;
    end else if (redirect_valid) begin
      fetch_misaligned <= redir_misaligned;
      if (redir_misaligned)
        misaligned_pc <= redirect_pc;
    end
  end
`else
  assign redir_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: random-latency memory, epoch-tagged reference model, directed scenarios.
module tb_riscv_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
  logic        fetch_misaligned;
  logic [31:0] misaligned_pc;
`endif

  riscv_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    .fetch_misaligned(fetch_misaligned), .misaligned_pc(misaligned_pc),
`endif
    .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    int          ep;
    int          due;
  } mreq_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] dat;
  } exp_t;

  mreq_t       mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_log[$];
  int          req_cyc[$];
  int          pop_cyc[$];

  int n_chk = 0, n_pass = 0, cyc = 0;
  int p_req_ready = 100, p_instr_ready = 100, p_redirect = 0, lat_min = 1, lat_max = 1;
  logic        rst_cmd = 1'b1;
  logic        redir_req = 1'b0;
  logic [31:0] redir_target = '0;

  int          epoch = 0;
  bit          fetching = 0, halted = 0;
  logic [31:0] exp_req_addr = '0, mis_pc = '0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic logic [31:0] rand_target();
    logic [31:0] t;
    t = $urandom_range(0, 1023) << 2;
    if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
`ifndef RISCV_FETCH_MISALIGN_CHECK_EN
    t[1:0] = 2'($urandom_range(0, 3));
`endif
    return t;
  endfunction

  function automatic logic [31:0] req_at(input int i);
    return (i < req_log.size()) ? req_log[i] : 32'hBAD0_BAD0;
  endfunction
  function automatic logic [31:0] pop_at(input int i);
    return (i < pop_log.size()) ? pop_log[i] : 32'hBAD0_BAD0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Input driver and memory model: everything changes 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    rst = rst_cmd;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (!rst && mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memfn(mem_q[0].addr);
      end
    end
    imem_req_ready = ($urandom_range(0, 99) < p_req_ready);
    instr_ready    = ($urandom_range(0, 99) < p_instr_ready);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    if (redir_req) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_target;
      redir_req      = 1'b0;
    end else if (!rst && p_redirect > 0) begin
      if ($urandom_range(0, 99) < p_redirect || (imem_rsp_valid && $urandom_range(0, 9) == 0)) begin
        redirect_valid = 1'b1;
        redirect_pc    = rand_target();
      end
    end
  end

  // Reference model and per-cycle compare on the falling edge.
  always @(negedge clk) begin : cmp
    bit    exp_rv, exp_iv;
    mreq_t e;
    if (rst) begin
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      mem_q.delete();
      exp_q.delete();
      fetching = 0; halted = 0; epoch = 0;
      exp_req_addr = 32'h0; mis_pc = 32'h0;
    end else begin
      exp_rv = fetching && !halted && !redirect_valid && (mem_q.size() + exp_q.size() < DEPTH);
      exp_iv = (exp_q.size() > 0) && !redirect_valid;
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (exp_rv && imem_req_valid) chk("req_addr", imem_req_addr, exp_req_addr);
      chk("instr_valid", 32'(instr_valid), 32'(exp_iv));
      if (exp_iv && instr_valid) begin
        chk("instr_pc", instr_pc, exp_q[0].pc);
        chk("instruction", instruction, exp_q[0].dat);
      end
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
      chk("misaligned_flag", 32'(fetch_misaligned), 32'(halted));
      chk("misaligned_pc", misaligned_pc, mis_pc);
`endif
      if (imem_req_valid && imem_req_ready) begin
        mem_q.push_back('{addr: imem_req_addr, pc: exp_req_addr, ep: epoch,
                          due: cyc + int'($urandom_range(lat_min, lat_max))});
        req_log.push_back(imem_req_addr);
        req_cyc.push_back(cyc);
        exp_req_addr = exp_req_addr + 32'd4;
      end
      if (instr_valid && instr_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        pop_log.push_back(instr_pc);
        pop_cyc.push_back(cyc);
      end
      if (imem_rsp_valid && mem_q.size() > 0) begin
        e = mem_q.pop_front();
        if (!redirect_valid && e.ep == epoch)
          exp_q.push_back('{pc: e.pc, dat: memfn(e.pc)});
      end
      if (redirect_valid) begin
        exp_q.delete();
        epoch++;
        exp_req_addr = redirect_pc & 32'hFFFF_FFFC;
`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
        halted = (redirect_pc[1:0] != 2'b00);
        if (halted) mis_pc = redirect_pc;
`endif
      end
      fetching = 1;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic clear_logs();
    req_log.delete(); pop_log.delete(); req_cyc.delete(); pop_cyc.delete();
  endtask

  task automatic do_reset(input int lmin, input int lmax, input int pir);
    rst_cmd = 1'b1; redir_req = 1'b0; p_redirect = 0; p_req_ready = 100;
    lat_min = lmin; lat_max = lmax; p_instr_ready = pir;
    wait_cyc(3);
    rst_cmd = 1'b0;
    clear_logs();
  endtask

  task automatic do_redirect(input logic [31:0] t);
    redir_target = t;
    redir_req = 1'b1;
    wait_cyc(1);
  endtask

  initial begin
    // 1: streaming from reset, 1-cycle memory
    do_reset(1, 1, 100);
    wait_cyc(8);
    chk("t1_req0", req_at(0), 32'h0);
    chk("t1_req1", req_at(1), 32'h4);
    chk("t1_req_gap", 32'(req_cyc[1] - req_cyc[0]), 32'd1);
    chk("t1_pop0", pop_at(0), 32'h0);
    chk("t1_pop1", pop_at(1), 32'h4);
    chk("t1_latency", 32'(pop_cyc[0] - req_cyc[0]), 32'd2);

    // 2: decoder stalled, credit limit of 2
    do_reset(1, 1, 0);
    wait_cyc(10);
    chk("t2_req_count", 32'(req_log.size()), 32'd2);
    chk("t2_req0", req_at(0), 32'h0);
    chk("t2_req1", req_at(1), 32'h4);
    p_instr_ready = 100;
    wait_cyc(10);
    chk("t2_pop0", pop_at(0), 32'h0);
    chk("t2_pop1", pop_at(1), 32'h4);
    chk("t2_resume", req_at(2), 32'h8);

    // 3: redirect with two 3-cycle fetches in flight
    do_reset(3, 3, 100);
    wait_cyc(3);
    do_redirect(32'h0000_0100);
    wait_cyc(1);
    chk("t3_empty_after", 32'(instr_valid), 32'd0);
    wait_cyc(12);
    chk("t3_req2", req_at(2), 32'h100);
    chk("t3_pop0", pop_at(0), 32'h100);
    chk("t3_pop1", pop_at(1), 32'h104);

    // 4: address wrap
    do_reset(1, 1, 100);
    wait_cyc(4);
    do_redirect(32'hFFFF_FFFC);
    clear_logs();
    wait_cyc(10);
    chk("t4_req0", req_at(0), 32'hFFFF_FFFC);
    chk("t4_req1", req_at(1), 32'h0);
    chk("t4_pop0", pop_at(0), 32'hFFFF_FFFC);
    chk("t4_pop1", pop_at(1), 32'h0);

    // 5: random ready, latency and redirects
    do_reset(1, 3, 70);
    p_req_ready = 50;
    p_redirect = 5;
    wait_cyc(3000);
    chk("t5_progress", 32'(pop_log.size() > 100), 32'd1);

`ifdef RISCV_FETCH_MISALIGN_CHECK_EN
    // 6: misaligned redirect halts, aligned redirect resumes
    do_reset(1, 1, 100);
    wait_cyc(4);
    do_redirect(32'h0000_0102);
    wait_cyc(1);
    chk("t6_flag_set", 32'(fetch_misaligned), 32'd1);
    chk("t6_pc", misaligned_pc, 32'h102);
    clear_logs();
    wait_cyc(6);
    chk("t6_no_req", 32'(req_log.size()), 32'd0);
    do_redirect(32'h0000_0200);
    clear_logs();
    wait_cyc(1);
    chk("t6_flag_clr", 32'(fetch_misaligned), 32'd0);
    wait_cyc(5);
    chk("t6_req0", req_at(0), 32'h200);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
